// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the 5-stage scalar/vector pipeline.
// Resolves load-use and branch hazards, selects bypass paths and sequences vector memory lanes in M.
module hazard_unit #(
    parameter int VLANES = 8,
    parameter int RW     = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [RW-1:0] rsD,
    input  logic [RW-1:0] rtD,
    input  logic [RW-1:0] rsE,
    input  logic [RW-1:0] rtE,
    input  logic [RW-1:0] writeregE,
    input  logic [RW-1:0] writeregM,
    input  logic [RW-1:0] writeregW,
    input  logic          regwriteE,
    input  logic          regwriteM,
    input  logic          regwriteW,
    input  logic          memtoregE,
    input  logic          memtoregM,
    input  logic [1:0]    branchD,
    input  logic          jumpD,
    input  logic          pcsrcD,
    input  logic          memwriteM,
    input  logic          memdataM,
    output logic          stallF,
    output logic          stallD,
    output logic          stallE,
    output logic          stallM,
    output logic          flushD,
    output logic          flushE,
    output logic          flushW,
    output logic          forwardaD,
    output logic          forwardbD,
    output logic [1:0]    forwardaE,
    output logic [1:0]    forwardbE,
    output logic [3:0]    vlaneM,
    output logic          vbusyM
);

    if (VLANES < 2 || VLANES > 16) begin : g_badLanes
        $error("hazard_unit: VLANES must be within 2..16");
    end

    localparam logic [3:0] LAST_LANE = 4'(VLANES - 1);

    typedef enum logic {IDLE, BUSY} vstate_t;

    vstate_t    state;
    vstate_t    stateNext;
    logic [3:0] lane;
    logic [3:0] laneNext;

    logic lwstall;
    logic branchstall;
    logic vtrig;
    logic vstall;

    // A producer only matches when it writes a real register; $0 never bypasses.
    function automatic logic regHit(logic [RW-1:0] src, logic we, logic [RW-1:0] dst);
        return (src != '0) && we && (dst == src);
    endfunction

    // ---------------- forwarding ----------------
    assign forwardaE = regHit(rsE, regwriteM, writeregM) ? 2'b10 :
                       regHit(rsE, regwriteW, writeregW) ? 2'b01 : 2'b00;
    assign forwardbE = regHit(rtE, regwriteM, writeregM) ? 2'b10 :
                       regHit(rtE, regwriteW, writeregW) ? 2'b01 : 2'b00;
    assign forwardaD = regHit(rsD, regwriteM, writeregM);
    assign forwardbD = regHit(rtD, regwriteM, writeregM);

    // ---------------- scalar hazards ----------------
    assign lwstall = memtoregE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));

    assign branchstall = (branchD != 2'b00) &&
        ((regwriteE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD))) ||
         (memtoregM && (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD))));

    // NOTE: vtrig is qualified by reset so the sequencer outputs stay quiet while reset is held,
    // even though the comb decode below would otherwise react to a vector op sitting in M.
    assign vtrig = reset && memdataM && (memwriteM || memtoregM);

    // ---------------- vector sequencer: state register ----------------
    // NOTE: state is updated with non-blocking assignments so every reader sees the pre-edge value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            lane  <= '0;
        end else begin
            state <= stateNext;
            lane  <= laneNext;
        end
    end

    // ---------------- vector sequencer: next state ----------------
    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        stateNext = state;
        laneNext  = lane;
        case (state)
            IDLE: begin
                if (vtrig) begin
                    stateNext = BUSY;
                    laneNext  = 4'd1;
                end else begin
                    laneNext  = '0;
                end
            end
            BUSY: begin
                if (lane == LAST_LANE) begin
                    stateNext = IDLE;
                    laneNext  = '0;
                end else begin
                    laneNext  = lane + 4'd1;
                end
            end
        endcase
    end

    // ---------------- vector sequencer: outputs ----------------
    always_comb begin
        vstall = 1'b0;
        vlaneM = '0;
        vbusyM = 1'b0;
        case (state)
            IDLE: begin
                vstall = vtrig;
                vbusyM = vtrig;
            end
            BUSY: begin
                vlaneM = lane;
                vbusyM = 1'b1;
                vstall = (lane != LAST_LANE);
            end
        endcase
    end

    // ---------------- pipeline control ----------------
    // The vector stall freezes E and M; a bubble in W keeps the frozen M op from retiring twice.
    assign stallF = lwstall || branchstall || vstall;
    assign stallD = stallF;
    assign stallE = vstall;
    assign stallM = vstall;
    assign flushW = vstall;
    assign flushE = (lwstall || branchstall) && !vstall;
    assign flushD = (pcsrcD || jumpD) && !stallD;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, lane-sequencing sequences
// and a randomized run compared against a cycle-level reference model.
module tb_hazard_unit;

    localparam int VLANES = 8;
    localparam int RW     = 5;

    typedef struct packed {
        logic [RW-1:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
        logic          regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
        logic [1:0]    branchD;
        logic          jumpD, pcsrcD, memwriteM, memdataM;
    } in_t;

    typedef struct packed {
        logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW, fwdaD, fwdbD;
        logic [1:0] fwdaE, fwdbE;
        logic [3:0] vlane;
        logic       vbusy;
    } out_t;

    typedef struct {
        string name;
        in_t   vin;
        out_t  exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN;
    in_t  stim;

    logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW, forwardaD, forwardbD, vbusyM;
    logic [1:0] forwardaE, forwardbE;
    logic [3:0] vlaneM;
    out_t       act;

    hazard_unit #(.VLANES(VLANES), .RW(RW)) dut (
        .clk       (clk),
        .reset     (rstN),
        .rsD       (stim.rsD),
        .rtD       (stim.rtD),
        .rsE       (stim.rsE),
        .rtE       (stim.rtE),
        .writeregE (stim.wrE),
        .writeregM (stim.wrM),
        .writeregW (stim.wrW),
        .regwriteE (stim.regwriteE),
        .regwriteM (stim.regwriteM),
        .regwriteW (stim.regwriteW),
        .memtoregE (stim.memtoregE),
        .memtoregM (stim.memtoregM),
        .branchD   (stim.branchD),
        .jumpD     (stim.jumpD),
        .pcsrcD    (stim.pcsrcD),
        .memwriteM (stim.memwriteM),
        .memdataM  (stim.memdataM),
        .stallF    (stallF),
        .stallD    (stallD),
        .stallE    (stallE),
        .stallM    (stallM),
        .flushD    (flushD),
        .flushE    (flushE),
        .flushW    (flushW),
        .forwardaD (forwardaD),
        .forwardbD (forwardbD),
        .forwardaE (forwardaE),
        .forwardbE (forwardbE),
        .vlaneM    (vlaneM),
        .vbusyM    (vbusyM)
    );

    assign act = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, forwardaD, forwardbD,
                  forwardaE, forwardbE, vlaneM, vbusyM};

    int nChecks = 0;
    int nPass   = 0;
    vec_t tbl[$];

    task automatic check(string nm, out_t got, out_t exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, exp, $time);
    endtask

    function automatic out_t mk(logic stFD, logic vst, logic flD, logic flE, logic faD, logic fbD,
                                logic [1:0] faE, logic [1:0] fbE, logic [3:0] ln, logic vb);
        out_t o;
        o.stallF = stFD;  o.stallD = stFD;
        o.stallE = vst;   o.stallM = vst;   o.flushW = vst;
        o.flushD = flD;   o.flushE = flE;
        o.fwdaD  = faD;   o.fwdbD  = fbD;
        o.fwdaE  = faE;   o.fwdbE  = fbE;
        o.vlane  = ln;    o.vbusy  = vb;
        return o;
    endfunction

    task automatic add(string nm, in_t t, out_t e);
        vec_t v;
        v.name = nm;
        v.vin  = t;
        v.exp  = e;
        tbl.push_back(v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model. vpos is the lane of a vector op already in progress, or -1 when none is.
    function automatic logic [1:0] fwdE(logic [RW-1:0] src, in_t i);
        if (src != 0 && i.regwriteM && i.wrM == src) return 2'b10;
        if (src != 0 && i.regwriteW && i.wrW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic out_t model(in_t i, logic rst, int vpos);
        out_t o;
        logic lw, br, vt, active, vst;
        int   ln;
        lw = i.memtoregE && i.rtE != 0 && (i.rtE == i.rsD || i.rtE == i.rtD);
        br = (i.branchD != 0) &&
             ((i.regwriteE && i.wrE != 0 && (i.wrE == i.rsD || i.wrE == i.rtD)) ||
              (i.memtoregM && i.wrM != 0 && (i.wrM == i.rsD || i.wrM == i.rtD)));
        vt     = rst && i.memdataM && (i.memwriteM || i.memtoregM);
        active = (vpos >= 0) || vt;
        ln     = (vpos >= 0) ? vpos : 0;
        vst    = active && (ln != VLANES - 1);
        o.stallF = lw || br || vst;
        o.stallD = o.stallF;
        o.stallE = vst;
        o.stallM = vst;
        o.flushW = vst;
        o.flushE = (lw || br) && !vst;
        o.flushD = (i.pcsrcD || i.jumpD) && !o.stallD;
        o.fwdaD  = i.rsD != 0 && i.regwriteM && i.wrM == i.rsD;
        o.fwdbD  = i.rtD != 0 && i.regwriteM && i.wrM == i.rtD;
        o.fwdaE  = fwdE(i.rsE, i);
        o.fwdbE  = fwdE(i.rtE, i);
        o.vlane  = active ? 4'(ln) : 4'd0;
        o.vbusy  = active;
        return o;
    endfunction

    function automatic int modelNext(in_t i, logic rst, int vpos);
        logic vt;
        int   ln;
        if (!rst) return -1;
        vt = i.memdataM && (i.memwriteM || i.memtoregM);
        if (vpos < 0 && !vt) return -1;
        ln = (vpos >= 0) ? vpos : 0;
        return (ln == VLANES - 1) ? -1 : ln + 1;
    endfunction

    function automatic in_t randIn();
        in_t r;
        r.rsD = RW'($urandom_range(0, 3));  r.rtD = RW'($urandom_range(0, 3));
        r.rsE = RW'($urandom_range(0, 3));  r.rtE = RW'($urandom_range(0, 3));
        r.wrE = RW'($urandom_range(0, 3));  r.wrM = RW'($urandom_range(0, 3));
        r.wrW = RW'($urandom_range(0, 3));
        r.regwriteE = 1'($urandom_range(0, 1));  r.regwriteM = 1'($urandom_range(0, 1));
        r.regwriteW = 1'($urandom_range(0, 1));  r.memtoregE = 1'($urandom_range(0, 1));
        r.memtoregM = 1'($urandom_range(0, 1));  r.branchD   = 2'($urandom_range(0, 3));
        r.jumpD     = ($urandom_range(0, 7) == 0);
        r.pcsrcD    = ($urandom_range(0, 7) == 0);
        r.memwriteM = 1'($urandom_range(0, 1));
        r.memdataM  = ($urandom_range(0, 9) < 3);
        return r;
    endfunction

    initial begin
        in_t t;
        int  vpos, nextVpos;
        logic [3:0] ln;

        // ---- reset held with a vector op in M ----
        rstN = 1'b0;
        stim = '0;
        #12;
        stim.memdataM = 1'b1;
        stim.memtoregM = 1'b1;
        #1 check("rst_vtrig", act, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 0));
        cyc();
        check("rst_vtrig_edge", act, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 0));
        stim = '0;
        rstN = 1'b1;
        #1;

        // ---- directed table, sequencer idle ----
        t = '0;                                                  add("idle", t, mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
        t = '0; t.rsE=5; t.wrM=5; t.regwriteM=1; t.wrW=5; t.regwriteW=1; add("fwdE_M", t, mk(0,0,0,0,0,0,2'b10,2'b00,0,0));
        t.regwriteM = 0;                                         add("fwdE_W", t, mk(0,0,0,0,0,0,2'b01,2'b00,0,0));
        t = '0; t.regwriteM=1; t.regwriteW=1;                    add("fwdE_r0", t, mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
        t = '0; t.rtE=7; t.wrM=7; t.regwriteM=1; t.wrW=7; t.regwriteW=1; add("fwdbE_M", t, mk(0,0,0,0,0,0,2'b00,2'b10,0,0));
        t.wrM = 6;                                               add("fwdbE_W", t, mk(0,0,0,0,0,0,2'b00,2'b01,0,0));
        t = '0; t.rsD=4; t.wrM=4; t.regwriteM=1;                 add("fwdaD", t, mk(0,0,0,0,1,0,2'b00,2'b00,0,0));
        t = '0; t.rtD=9; t.wrM=9; t.regwriteM=1;                 add("fwdbD", t, mk(0,0,0,0,0,1,2'b00,2'b00,0,0));
        t = '0; t.regwriteM=1;                                   add("fwdD_r0", t, mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
        t = '0; t.memtoregE=1; t.rtE=3; t.rsD=3;                 add("lw_rs", t, mk(1,0,0,1,0,0,2'b00,2'b00,0,0));
        t = '0; t.memtoregE=1; t.rtE=3; t.rtD=3;                 add("lw_rt", t, mk(1,0,0,1,0,0,2'b00,2'b00,0,0));
        t = '0; t.memtoregE=1; t.rtD=5;                          add("lw_r0", t, mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
        t = '0; t.branchD=1; t.regwriteE=1; t.wrE=6; t.rtD=6;    add("br_E", t, mk(1,0,0,1,0,0,2'b00,2'b00,0,0));
        t = '0; t.branchD=2; t.memtoregM=1; t.wrM=8; t.rsD=8;    add("br_M", t, mk(1,0,0,1,0,0,2'b00,2'b00,0,0));
        t = '0; t.regwriteE=1; t.wrE=6; t.rtD=6;                 add("nobr", t, mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
        t = '0; t.jumpD=1;                                       add("jump", t, mk(0,0,1,0,0,0,2'b00,2'b00,0,0));
        t = '0; t.pcsrcD=1; t.memtoregE=1; t.rtE=3; t.rsD=3;     add("pcsrc_stall", t, mk(1,0,0,1,0,0,2'b00,2'b00,0,0));
        t = '0; t.branchD=1; t.regwriteE=1;                      add("br_r0", t, mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
        t = '0; t.branchD=3; t.regwriteM=1; t.wrM=4; t.rsD=4; t.pcsrcD=1; add("br_fwd", t, mk(0,0,1,0,1,0,2'b00,2'b00,0,0));

        for (int k = 0; k < tbl.size(); k++) begin
            stim = tbl[k].vin;
            #2 check(tbl[k].name, act, tbl[k].exp);
        end

        // ---- vector load with a concurrent load-use hazard and a jump ----
        cyc();
        stim = '0;
        stim.memtoregM = 1; stim.memdataM = 1;
        stim.memtoregE = 1; stim.rtE = 3; stim.rsD = 3; stim.jumpD = 1;
        for (int l = 0; l < VLANES; l++) begin
            ln = 4'(l);
            #1 check("vload", act, mk(1, l != VLANES-1, 0, l == VLANES-1, 0, 0, 2'b00, 2'b00, ln, 1));
            if (l == VLANES - 1) stim = '0;
            cyc();
        end
        #1 check("vload_done", act, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 0));

        // ---- back-to-back vector store then vector load ----
        cyc();
        stim = '0;
        stim.memwriteM = 1; stim.memdataM = 1;
        for (int i = 0; i < 2 * VLANES; i++) begin
            if (i == VLANES) begin
                stim.memwriteM = 0;
                stim.memtoregM = 1;
            end
            ln = 4'(i % VLANES);
            #1 check("b2b", act, mk((i % VLANES) != VLANES-1, (i % VLANES) != VLANES-1, 0, 0, 0, 0,
                                    2'b00, 2'b00, ln, 1));
            if (i == 2 * VLANES - 1) stim = '0;
            cyc();
        end
        #1 check("b2b_done", act, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 0));

        // ---- reset pulse at lane 4 ----
        cyc();
        stim = '0;
        stim.memwriteM = 1; stim.memdataM = 1;
        repeat (4) cyc();
        #1 check("mid_lane4", act, mk(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'd4, 1));
        rstN = 1'b0;
        #1 check("mid_reset", act, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 0));
        #1 rstN = 1'b1;
        #1 check("restart_lane0", act, mk(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 1));
        cyc();
        check("restart_lane1", act, mk(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'd1, 1));
        stim = '0;
        rstN = 1'b0;
        #1 rstN = 1'b1;

        // ---- randomized run against the reference model ----
        nextVpos = -1;
        vpos     = -1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            vpos = nextVpos;
            #1;
            stim = randIn();
            rstN = ($urandom_range(0, 99) >= 3);
            if (!rstN) vpos = -1;
            #2 check("rand", act, model(stim, rstN, vpos));
            nextVpos = modelNext(stim, rstN, vpos);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard and forwarding controller for the 5-stage scalar/vector core.
- Consumes decode/execute/memory/writeback control and register indices from the processor controller and datapath.
- Produces the flushE input of the controller, plus stall, flush, forwarding and lane-sequencing signals.
- Adds a multi-cycle sequencer that holds vector memory ops in M for VLANES cycles, one lane word per cycle.

Parameters:
- VLANES, 8, lanes per vector memory access; legal range 2..16.
- RW, 5, register index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- rsD, rtD  in  RW  source registers in D.
- rsE, rtE  in  RW  source registers in E.
- writeregE, writeregM, writeregW  in  RW  destination registers.
- regwriteE, regwriteM, regwriteW  in  1  scalar writeback enables.
- memtoregE, memtoregM  in  1  load flags.
- branchD  in  2  branch type; nonzero = branch.
- jumpD, pcsrcD  in  1  jump / branch-taken in D.
- memwriteM, memdataM  in  1  store flag / vector-memory flag in M.
- stallF, stallD, stallE, stallM  out  1  hold the PC and D/E/M pipeline registers.
- flushD, flushE, flushW  out  1  bubble insertion.
- forwardaD, forwardbD  out  1  M→D forward for branch compare.
- forwardaE, forwardbE  out  2  00 regfile, 10 from M, 01 from W.
- vlaneM  out  4  current lane index of the vector access.
- vbusyM  out  1  vector sequencer active.

Behaviour:
- Forwarding, combinational:
  - forwardaE = 10 if rsE!=0 & regwriteM & writeregM==rsE.
  - Otherwise 01 if rsE!=0 & regwriteW & writeregW==rsE.
  - Otherwise 00. M has priority over W. forwardbE is identical using rtE.
  - forwardaD = rsD!=0 & regwriteM & writeregM==rsD; forwardbD likewise using rtD.
- lwstall = memtoregE & (rtE==rsD | rtE==rtD).
- branchstall = (branchD!=0) & ((regwriteE & (writeregE==rsD | writeregE==rtD)) | (memtoregM & (writeregM==rsD | writeregM==rtD))).
- Vector sequencer FSM; state and lane counter reset to IDLE, 0.
  - vtrig = memdataM & (memwriteM | memtoregM).
  - IDLE: vlaneM=0. If vtrig, vstall=1 and next state is BUSY with lane=1. Otherwise vstall=0.
  - BUSY: vlaneM=lane and vbusyM=1. If lane!=VLANES-1, vstall=1 and lane increments. If lane==VLANES-1, vstall=0 and next state is IDLE with lane=0.
  - A vector op therefore occupies M for exactly VLANES cycles, with lanes 0..VLANES-1 in order.
  - vbusyM = vtrig in IDLE | BUSY.
  - vtrig is not evaluated in BUSY. The final-lane cycle is the last cycle of that op, so the next cycle's M op is a new instruction.
- Outputs:
  - stallF = stallD = lwstall | branchstall | vstall.
  - stallE = stallM = vstall.
  - flushW = vstall: a bubble goes into W so the frozen M op is not written back twice.
  - flushE = (lwstall | branchstall) & !vstall.
  - flushD = (pcsrcD | jumpD) & !stallD.
- Boundary conditions:
  - Register 0 never forwards and never triggers a stall.
  - Vector stall dominates all other hazards, so flushE=0 and flushD=0 while vstall.
  - Back-to-back vector ops: the second triggers in the IDLE cycle immediately after the first completes.
  - Reset asserted mid-BUSY: state goes IDLE and lane goes 0 immediately (asynchronous), so vstall drops the same cycle.
  - All outputs are combinational from inputs and state. In reset only forwarding, lwstall and branchstall terms can be nonzero; vlaneM=0 and vbusyM=0.

Test Plan:
- Reset: reset=0 with vtrig=1 → vbusyM=0, vlaneM=0, stallM=0. After release, the first vtrig starts at lane 0.
- Forwarding: rsE=5, writeregM=5/regwriteM=1, writeregW=5/regwriteW=1 → forwardaE=10. Drop regwriteM → 01. Set rsE=0 → 00.
- Load-use: memtoregE=1, rtE=3, rsD=3 → stallF=stallD=1, flushE=1, stallE=0. Branch with regwriteE & writeregE==rtD → same outputs.
- Vector load, VLANES=8: vtrig held → vlaneM sequence 0..7 over 8 cycles. stallM=flushW=1 for 7 cycles, then 0 on lane 7. A concurrent lwstall gives flushE=0 during the stall.
- Back-to-back vector store then vector load → 16 consecutive cycles with vlaneM 0..7, 0..7. vbusyM stays 1 throughout; stallM=0 only on the two lane-7 cycles.
- Reset pulse at lane 4 → vlaneM=0 and stallM=0 immediately. A new vtrig after release restarts at lane 0.
